conv_sequencer: RTL and testbench

Sequential controller that computes one same-padded 2-D convolution layer on shared memories, one multiply-accumulate per clock. It walks output channel, row, column and kernel tap, and issues read addresses to the input, kernel and bias memories. It accumulates in a widened accumulator and writes one saturated fixed-point result per output pixel. It is the time-multiplexed counterpart of the combinational `Convolutional` layer and uses the same memory layouts and number format.

---
 rtl/conv_sequencer_if.sv | 40 ++++
 rtl/conv_sequencer.sv | 153 +++++++++++++++
 tb/tb_conv_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_sequencer_if.sv
// Bus between conv_sequencer (master) and its memories/controller (slave).
interface conv_sequencer_if #(
  parameter int IN_DEPTH    = 2,
  parameter int IN_HEIGHT   = 5,
  parameter int IN_WIDTH    = 5,
  parameter int OUT_DEPTH   = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_W      = 18
);
  localparam int NIN   = IN_DEPTH * IN_HEIGHT * IN_WIDTH;
  localparam int NKERN = KERNEL_SIZE * KERNEL_SIZE * IN_DEPTH * OUT_DEPTH;
  localparam int NOUT  = OUT_DEPTH * IN_HEIGHT * IN_WIDTH;
  localparam int IA_W  = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int KA_W  = (NKERN > 1) ? $clog2(NKERN) : 1;
  localparam int BA_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OA_W  = (NOUT > 1) ? $clog2(NOUT) : 1;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [IA_W-1:0]          in_addr;
  logic signed [DATA_W-1:0] in_data;
  logic [KA_W-1:0]          kern_addr;
  logic signed [DATA_W-1:0] kern_data;
  logic [BA_W-1:0]          bias_addr;
  logic signed [DATA_W-1:0] bias_data;
  logic [OA_W-1:0]          out_addr;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_we;

  modport master (
    input  start, in_data, kern_data, bias_data,
    output busy, done, in_addr, kern_addr, bias_addr, out_addr, out_data, out_we
  );

  modport slave (
    output start, in_data, kern_data, bias_data,
    input  busy, done, in_addr, kern_addr, bias_addr, out_addr, out_data, out_we
  );
endinterface

// File: rtl/conv_sequencer.sv
// Time-multiplexed same-padded 2-D convolution layer, one MAC per clock.
// Define CONV_SEQ_RELU_EN to clamp negative results to zero on write.
module conv_sequencer #(
  parameter int IN_DEPTH    = 2,
  parameter int IN_HEIGHT   = 5,
  parameter int IN_WIDTH    = 5,
  parameter int OUT_DEPTH   = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_W      = 18,
  parameter int FRAC        = 9,
  parameter int ACC_W       = 2*DATA_W+8
) (
  input  logic             clk,
  input  logic             rst,
  conv_sequencer_if.master bus
);
  localparam int K     = KERNEL_SIZE;
  localparam int P     = (K-1)/2;
  localparam int HW    = IN_HEIGHT * IN_WIDTH;
  localparam int NIN   = IN_DEPTH * HW;
  localparam int NKERN = K * K * IN_DEPTH * OUT_DEPTH;
  localparam int NOUT  = OUT_DEPTH * HW;
  localparam int IA_W  = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int KA_W  = (NKERN > 1) ? $clog2(NKERN) : 1;
  localparam int OA_W  = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int CO_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int RW_W  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int CL_W  = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int CI_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int KK_W  = (K > 1) ? $clog2(K) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, WRITE, DONE} state_t;
  state_t state, state_nx;

  logic [CO_W-1:0] cout;
  logic [RW_W-1:0] row;
  logic [CL_W-1:0] col;
  logic [CI_W-1:0] cin;
  logic [KK_W-1:0] kh, kw;
  logic            last_tap, last_pix, first_tap;
  logic            pad, pad_d, mac_d;
  logic [IA_W-1:0] in_addr_q;
  logic signed [31:0] tr, tc, in_lin;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, shifted, sum;
  logic signed [DATA_W-1:0] sat;

  assign last_tap  = (cin == CI_W'(IN_DEPTH-1)) && (kh == KK_W'(K-1)) && (kw == KK_W'(K-1));
  assign first_tap = (cin == '0) && (kh == '0) && (kw == '0);
  assign last_pix  = (cout == CO_W'(OUT_DEPTH-1)) && (row == RW_W'(IN_HEIGHT-1)) &&
                     (col == CL_W'(IN_WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = MAC;
      MAC:     if (last_tap) state_nx = DRAIN;
      DRAIN:   state_nx = WRITE;
      WRITE:   state_nx = last_pix ? DONE : MAC;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Tap counters wrap to zero on the last tap and pixel counters on the last
  // pixel, so every pixel and every new run starts from an all-zero position.
  always_ff @(posedge clk) begin
    if (rst) begin
      cout <= '0; row <= '0; col <= '0; cin <= '0; kh <= '0; kw <= '0;
    end else if (state == MAC) begin
      if (kw == KK_W'(K-1)) begin
        kw <= '0;
        if (kh == KK_W'(K-1)) begin
          kh  <= '0;
          cin <= (cin == CI_W'(IN_DEPTH-1)) ? '0 : cin + CI_W'(1);
        end else begin
          kh <= kh + KK_W'(1);
        end
      end else begin
        kw <= kw + KK_W'(1);
      end
    end else if (state == WRITE) begin
      if (col == CL_W'(IN_WIDTH-1)) begin
        col <= '0;
        if (row == RW_W'(IN_HEIGHT-1)) begin
          row  <= '0;
          cout <= (cout == CO_W'(OUT_DEPTH-1)) ? '0 : cout + CO_W'(1);
        end else begin
          row <= row + RW_W'(1);
        end
      end else begin
        col <= col + CL_W'(1);
      end
    end
  end

  always_comb begin
    tr     = int'(row) + int'(kh) - P;
    tc     = int'(col) + int'(kw) - P;
    pad    = (tr < 0) || (tr >= IN_HEIGHT) || (tc < 0) || (tc >= IN_WIDTH);
    in_lin = int'(cin) * HW + tr * IN_WIDTH + tc;
    bus.in_addr = pad ? in_addr_q : IA_W'(in_lin);
  end

  assign bus.kern_addr = KA_W'(((int'(kh) * K + int'(kw)) * IN_DEPTH + int'(cin)) * OUT_DEPTH + int'(cout));
  assign bus.bias_addr = cout;
  assign bus.out_addr  = OA_W'(int'(cout) * HW + int'(row) * IN_WIDTH + int'(col));
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.out_we    = (state == WRITE);

  assign prod = bus.in_data * bus.kern_data;

  // Memory data arrives one cycle after issue, so the tap's pad/valid flags
  // are delayed to line up with it; the last product lands during DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_addr_q <= '0;
      pad_d     <= 1'b0;
      mac_d     <= 1'b0;
      acc       <= '0;
    end else begin
      in_addr_q <= bus.in_addr;
      pad_d     <= pad;
      mac_d     <= (state == MAC);
      if (state == MAC && first_tap)
        acc <= '0;
      else if (mac_d && !pad_d)
        acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

  always_comb begin
    shifted = acc >>> FRAC;
    sum     = shifted + $signed({{(ACC_W-DATA_W){bus.bias_data[DATA_W-1]}}, bus.bias_data});
    if (sum > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
    else if (sum < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
    else                    sat = sum[DATA_W-1:0];
`ifdef CONV_SEQ_RELU_EN
    if (sat[DATA_W-1]) sat = '0;
`else
    sat = sat;
`endif
    bus.out_data = (state == WRITE) ? sat : '0;
  end
endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench for conv_sequencer: a reference model queues expected writes, a monitor checks them.
module tb_conv_sequencer;
  localparam int IN_DEPTH  = 2;
  localparam int IN_HEIGHT = 5;
  localparam int IN_WIDTH  = 5;
  localparam int OUT_DEPTH = 32;
  localparam int K         = 3;
  localparam int DATA_W    = 18;
  localparam int FRAC      = 9;
  localparam int P         = (K-1)/2;
  localparam int HW        = IN_HEIGHT * IN_WIDTH;
  localparam int NIN       = IN_DEPTH * HW;
  localparam int NKERN     = K * K * IN_DEPTH * OUT_DEPTH;
  localparam int NOUT      = OUT_DEPTH * HW;
  localparam int T         = IN_DEPTH * K * K;
  localparam int DONE_CYC  = NOUT * (T+2) + 1;
  localparam int CENTRE    = 2*IN_WIDTH + 2;

  logic clk = 1'b0;
  logic rst;

  conv_sequencer_if #(.IN_DEPTH(IN_DEPTH), .IN_HEIGHT(IN_HEIGHT), .IN_WIDTH(IN_WIDTH),
                      .OUT_DEPTH(OUT_DEPTH), .KERNEL_SIZE(K), .DATA_W(DATA_W)) bus ();

  conv_sequencer #(.IN_DEPTH(IN_DEPTH), .IN_HEIGHT(IN_HEIGHT), .IN_WIDTH(IN_WIDTH),
                   .OUT_DEPTH(OUT_DEPTH), .KERNEL_SIZE(K), .DATA_W(DATA_W), .FRAC(FRAC),
                   .ACC_W(2*DATA_W+8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int in_mem[NIN];
  int kern_mem[NKERN];
  int bias_mem[OUT_DEPTH];

  // Synchronous-read memories: data follows the address by one cycle.
  always @(posedge clk) begin
    bus.in_data   <= (int'(bus.in_addr) < NIN) ? DATA_W'(in_mem[bus.in_addr]) : '0;
    bus.kern_data <= (int'(bus.kern_addr) < NKERN) ? DATA_W'(kern_mem[bus.kern_addr]) : '0;
    bus.bias_data <= (int'(bus.bias_addr) < OUT_DEPTH) ? DATA_W'(bias_mem[bus.bias_addr]) : '0;
  end

  typedef struct { int addr; int data; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int we_count = 0;
  int got[NOUT];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int a, d;
    if (bus.out_we === 1'b1) begin
      we_count++;
      a = int'(bus.out_addr);
      d = int'(bus.out_data);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%0d expected=none", a, d);
      end else begin
        e = sb.pop_front();
        check("out_addr", a, e.addr);
        check($sformatf("out_data[%0d]", e.addr), d, e.data);
      end
      if (a < NOUT) got[a] = d;
    end
  end

  // Reference: direct sum over in-range taps, floor shift, bias, clamp.
  function automatic int ref_pixel(input int co, input int r, input int c);
    longint acc, v;
    int ir, ic;
    acc = 0;
    for (int ci = 0; ci < IN_DEPTH; ci++)
      for (int kh = 0; kh < K; kh++)
        for (int kw = 0; kw < K; kw++) begin
          ir = r + kh - P;
          ic = c + kw - P;
          if (ir >= 0 && ir < IN_HEIGHT && ic >= 0 && ic < IN_WIDTH)
            acc += longint'(in_mem[ci*HW + ir*IN_WIDTH + ic]) *
                   longint'(kern_mem[((kh*K + kw)*IN_DEPTH + ci)*OUT_DEPTH + co]);
        end
    v = (acc >>> FRAC) + longint'(bias_mem[co]);
    if (v > 131071) v = 131071;
    if (v < -131072) v = -131072;
`ifdef CONV_SEQ_RELU_EN
    if (v < 0) v = 0;
`endif
    return int'(v);
  endfunction

  task automatic push_expected();
    for (int co = 0; co < OUT_DEPTH; co++)
      for (int r = 0; r < IN_HEIGHT; r++)
        for (int c = 0; c < IN_WIDTH; c++)
          sb.push_back('{co*HW + r*IN_WIDTH + c, ref_pixel(co, r, c)});
  endtask

  task automatic fill(input int in_v, input int k_even, input int k_odd, input int bias_step);
    for (int i = 0; i < NIN; i++) in_mem[i] = in_v;
    for (int i = 0; i < NKERN; i++) kern_mem[i] = ((i % OUT_DEPTH) % 2 == 0) ? k_even : k_odd;
    for (int i = 0; i < OUT_DEPTH; i++) bias_mem[i] = i * bias_step;
  endtask

  // Full run; n tracks the cycle index with start sampled in cycle 0.
  task automatic run(input string tag, input bit pulses);
    int n;
    we_count = 0;
    push_expected();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; n = 1;
    check({tag, "_busy_c1"}, int'(bus.busy), 1);
    while (n <= DONE_CYC + 50) begin
      bus.start = (pulses && (n == 5 || n == 300)) ? 1'b1 : 1'b0;
      if (bus.done === 1'b1) break;
      @(negedge clk); n++;
    end
    bus.start = 1'b0;
    check({tag, "_done_cycle"}, n, DONE_CYC);
    check({tag, "_we_count"}, we_count, NOUT);
    check({tag, "_sb_left"}, sb.size(), 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(bus.done), 0);
    check({tag, "_busy_idle"}, int'(bus.busy), 0);
    sb.delete();
  endtask

  task automatic abort_run(input int at);
    int n, saw_done, late_we;
    push_expected();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; n = 1;
    while (n < at) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_out_we", int'(bus.out_we), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_in_addr", int'(bus.in_addr), 0);
    check("abort_kern_addr", int'(bus.kern_addr), 0);
    check("abort_out_addr", int'(bus.out_addr), 0);
    sb.delete();
    saw_done = 0;
    late_we = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done++;
      if (bus.out_we === 1'b1) late_we++;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_no_write", late_we, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b1;
    fill(512, 512, 512, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_out_we", int'(bus.out_we), 0);
    check("rst_out_data", int'(bus.out_data), 0);
    check("rst_in_addr", int'(bus.in_addr), 0);
    check("rst_kern_addr", int'(bus.kern_addr), 0);
    check("rst_bias_addr", int'(bus.bias_addr), 0);
    check("rst_out_addr", int'(bus.out_addr), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("start_with_rst_ignored", int'(bus.busy), 0);

    run("ones", 1'b0);
    check("ones_centre", got[CENTRE], 9216);
    check("ones_corner", got[0], 4096);
    for (int co = 0; co < OUT_DEPTH; co++)
      check($sformatf("ones_edge_c%0d", co), got[co*HW + 2], 6144);

    fill(512, 512, 512, 256);
    run("bias", 1'b1);
    check("bias_c3_centre", got[3*HW + CENTRE], 9984);

    fill(51200, 512, -512, 0);
    run("sat", 1'b0);
    check("sat_pos_centre", got[CENTRE], 131071);
`ifdef CONV_SEQ_RELU_EN
    check("sat_neg_centre", got[HW + CENTRE], 0);
`else
    check("sat_neg_centre", got[HW + CENTRE], -131072);
`endif

    fill(512, 512, 512, 0);
    abort_run(1000);

    for (int i = 0; i < NIN; i++) in_mem[i] = int'($urandom_range(0, 30720)) - 15360;
    for (int i = 0; i < NKERN; i++) kern_mem[i] = int'($urandom_range(0, 1024)) - 512;
    for (int i = 0; i < OUT_DEPTH; i++) bias_mem[i] = int'($urandom_range(0, 4096)) - 2048;
    run("random", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
